response_unit: RTL and testbench

- Return path of the host UART link. The command path decodes host bytes into control strobes; this block sends acquisition results back to the host.
- Accepts one sample word plus a 4-bit tag over a valid/ready handshake.
- Serializes it as a multi-byte 8N1 UART packet: header byte, then data bytes.
- Contains its own bit-period counter, so it needs no external UART core.

---
 rtl/response_unit.sv | 162 ++++++++++++++++
 tb/tb_response_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/response_unit.sv
// UART return path: serializes one tagged sample word as an 8N1 packet (header + MSB-first data bytes).
// Define RESP_CHECKSUM_EN to append an XOR trailer byte covering the header and data bytes.
module response_unit #(
  parameter int SAMPLE_SIZE  = 16,
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [SAMPLE_SIZE-1:0] i_data,
  input  logic [3:0]             i_tag,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic                   o_tx,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int NB = SAMPLE_SIZE / 8;
`ifdef RESP_CHECKSUM_EN
  localparam int LAST_BYTE = NB + 1;
`else
  localparam int LAST_BYTE = NB;
`endif
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [2:0]             byte_cnt_q, byte_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [SAMPLE_SIZE-1:0] data_q, data_d;
  logic                   tx_q, tx_d;
  logic                   done_q, done_d;
  logic                   period_end;
`ifdef RESP_CHECKSUM_EN
  logic [7:0]             csum_q, csum_d;
`endif

  assign period_end = (bit_cnt_q == CNT_LAST);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
`ifdef RESP_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
`ifdef RESP_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    done_d     = 1'b0;
`ifdef RESP_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          state_d    = S_START;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          shift_d    = {4'hA, i_tag};
          data_d     = i_data;
`ifdef RESP_CHECKSUM_EN
          csum_d     = {4'hA, i_tag};
`endif
        end
      end
      S_START: begin
        if (period_end) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (period_end) begin
          bit_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        // Final stop bit: return to IDLE one cycle early so its last cycle
        // can already accept the next word without an idle gap on the line.
        if (byte_cnt_q == 3'(LAST_BYTE)) begin
          if (bit_cnt_q == CNT_PRE) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (period_end) begin
          state_d    = S_START;
          bit_cnt_d  = '0;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q < 3'(NB)) begin
            shift_d = data_q[SAMPLE_SIZE-1 -: 8];
            data_d  = data_q << 8;
`ifdef RESP_CHECKSUM_EN
            csum_d  = csum_q ^ data_q[SAMPLE_SIZE-1 -: 8];
`endif
          end
`ifdef RESP_CHECKSUM_EN
          else begin
            shift_d = csum_q;
          end
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign o_tx    = tx_q;
  assign o_done  = done_q;
  assign o_ready = (state_q == S_IDLE);
  assign o_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_response_unit.sv
// Directed bench for response_unit at CLKS_PER_BIT=4, SAMPLE_SIZE=16; decodes o_tx from a per-cycle log.
module tb_response_unit;
  localparam int CPB = 4;
  localparam int SS  = 16;
`ifdef RESP_CHECKSUM_EN
  localparam int PKT = 160;
`else
  localparam int PKT = 120;
`endif

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b0;
  logic [SS-1:0] i_data  = '0;
  logic [3:0]    i_tag   = '0;
  logic          i_valid = 1'b0;
  logic          o_ready, o_tx, o_busy, o_done;

  int checks = 0;
  int errors = 0;

  logic tx_log[$];
  logic done_log[$];
  bit   log_en = 1'b0;

  response_unit #(.SAMPLE_SIZE(SS), .CLKS_PER_BIT(CPB)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_data(i_data), .i_tag(i_tag),
    .i_valid(i_valid), .o_ready(o_ready), .o_tx(o_tx), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clock = ~i_clock;

  // Log index k holds the line state during the (k+1)-th cycle after the transfer edge.
  always @(posedge i_clock) begin
    #2;
    if (log_en) begin
      tx_log.push_back(o_tx);
      done_log.push_back(o_done);
    end
  end

  function automatic logic [7:0] dec_byte(input int base);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[j] = tx_log[base + CPB*(1+j) + 1];
    return b;
  endfunction

  task automatic ncyc(input int n);
    repeat (n) @(negedge i_clock);
  endtask

  task automatic start_log();
    tx_log.delete();
    done_log.delete();
    log_en = 1'b1;
  endtask

  task automatic send(input logic [SS-1:0] d, input logic [3:0] t);
    @(negedge i_clock);
    i_data = d; i_tag = t; i_valid = 1'b1;
    start_log();
    @(negedge i_clock);
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    int bad_tx, bad_rdy, bad_busy, bad_done;
    bad_tx = 0; bad_rdy = 0; bad_busy = 0; bad_done = 0;
    #2 i_reset = 1'b1;
    #1;
    checks++; if (o_tx !== 1'b1)    begin errors++; $display("FAIL reset_tx got %b exp 1", o_tx); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", o_ready); end
    checks++; if (o_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
    checks++; if (o_done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b exp 0", o_done); end
    ncyc(3);
    i_reset = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge i_clock);
      if (o_tx !== 1'b1) bad_tx++;
      if (o_ready !== 1'b1) bad_rdy++;
      if (o_busy !== 1'b0) bad_busy++;
      if (o_done !== 1'b0) bad_done++;
    end
    checks++; if (bad_tx != 0)   begin errors++; $display("FAIL idle_tx bad cycles %0d exp 0", bad_tx); end
    checks++; if (bad_rdy != 0)  begin errors++; $display("FAIL idle_ready bad cycles %0d exp 0", bad_rdy); end
    checks++; if (bad_busy != 0) begin errors++; $display("FAIL idle_busy bad cycles %0d exp 0", bad_busy); end
    checks++; if (bad_done != 0) begin errors++; $display("FAIL idle_done bad cycles %0d exp 0", bad_done); end
  endtask

  task automatic test_single();
    logic [7:0] exp_b[3];
    int nd, first;
    exp_b = '{8'hA5, 8'h12, 8'h34};
    send(16'h1234, 4'h5);
    #1;
    checks++; if (o_busy !== 1'b1 || o_ready !== 1'b0) begin errors++; $display("FAIL single_busy got busy=%b ready=%b exp 1/0", o_busy, o_ready); end
    ncyc(PKT + 10);
    checks++; if (tx_log[0] !== 1'b0) begin errors++; $display("FAIL single_start_latency got %b exp 0", tx_log[0]); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dec_byte(40*i) !== exp_b[i]) begin errors++; $display("FAIL single_byte%0d got %h exp %h", i, dec_byte(40*i), exp_b[i]); end
      checks++;
      if (tx_log[40*i+1] !== 1'b0 || tx_log[40*i+37] !== 1'b1) begin
        errors++; $display("FAIL single_frame%0d got start=%b stop=%b exp 0/1", i, tx_log[40*i+1], tx_log[40*i+37]);
      end
    end
    nd = 0; first = -1;
    foreach (done_log[k]) if (done_log[k] === 1'b1) begin nd++; if (first < 0) first = k; end
    checks++; if (first != PKT-1) begin errors++; $display("FAIL single_done_time got %0d exp %0d", first + 1, PKT); end
    checks++; if (nd != 1) begin errors++; $display("FAIL single_done_count got %0d exp 1", nd); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b[6];
    int base[6];
    int nd, first, second;
    exp_b = '{8'hA0, 8'hFF, 8'h00, 8'hA0, 8'h00, 8'hFF};
    base  = '{0, 40, 80, PKT, PKT+40, PKT+80};
    @(negedge i_clock);
    i_data = 16'hFF00; i_tag = 4'h0; i_valid = 1'b1;
    start_log();
    ncyc(1);
    i_data = 16'h00FF;
    ncyc(PKT);
    i_valid = 1'b0;
    ncyc(PKT + 10);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (dec_byte(base[i]) !== exp_b[i]) begin errors++; $display("FAIL b2b_byte%0d got %h exp %h", i, dec_byte(base[i]), exp_b[i]); end
    end
    checks++; if (tx_log[PKT-1] !== 1'b1 || tx_log[PKT] !== 1'b0) begin
      errors++; $display("FAIL b2b_gap got stop=%b start=%b exp 1/0", tx_log[PKT-1], tx_log[PKT]);
    end
    nd = 0; first = -1; second = -1;
    foreach (done_log[k]) if (done_log[k] === 1'b1) begin
      nd++;
      if (first < 0) first = k; else if (second < 0) second = k;
    end
    checks++; if (nd != 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", nd); end
    checks++; if (first != PKT-1 || second != 2*PKT-1) begin
      errors++; $display("FAIL b2b_done_time got %0d,%0d exp %0d,%0d", first+1, second+1, PKT, 2*PKT);
    end
  endtask

  task automatic test_ignore_busy();
    logic [7:0] exp_b[3];
    int nd, zeros;
    exp_b = '{8'hA3, 8'h55, 8'h55};
    send(16'h5555, 4'h3);
    ncyc(9);
    i_data = 16'hAAAA; i_tag = 4'hF;
    ncyc(40);
    i_valid = 1'b1;
    ncyc(1);
    i_valid = 1'b0;
    ncyc(2*PKT);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dec_byte(40*i) !== exp_b[i]) begin errors++; $display("FAIL ignore_byte%0d got %h exp %h", i, dec_byte(40*i), exp_b[i]); end
    end
    nd = 0; zeros = 0;
    foreach (done_log[k]) if (done_log[k] === 1'b1) nd++;
    for (int k = PKT; k < tx_log.size(); k++) if (tx_log[k] !== 1'b1) zeros++;
    checks++; if (nd != 1) begin errors++; $display("FAIL ignore_done_count got %0d exp 1", nd); end
    checks++; if (zeros != 0) begin errors++; $display("FAIL ignore_extra_packet low cycles %0d exp 0", zeros); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_b[3];
    int nd;
    exp_b = '{8'hA0, 8'hAB, 8'hCD};
    send(16'h1234, 4'h0);
    ncyc(85);
    checks++; if (o_tx !== 1'b0) begin errors++; $display("FAIL rstmid_pre_tx got %b exp 0", o_tx); end
    i_reset = 1'b1;
    #1;
    checks++; if (o_tx !== 1'b1) begin errors++; $display("FAIL rstmid_async_tx got %b exp 1", o_tx); end
    checks++; if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_flags got ready=%b busy=%b exp 1/0", o_ready, o_busy);
    end
    ncyc(2);
    i_reset = 1'b0;
    ncyc(PKT);
    nd = 0;
    foreach (done_log[k]) if (done_log[k] === 1'b1) nd++;
    checks++; if (nd != 0) begin errors++; $display("FAIL rstmid_no_done got %0d exp 0", nd); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", o_ready); end
    send(16'hABCD, 4'h0);
    ncyc(PKT + 10);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dec_byte(40*i) !== exp_b[i]) begin errors++; $display("FAIL rstmid_byte%0d got %h exp %h", i, dec_byte(40*i), exp_b[i]); end
    end
  endtask

`ifdef RESP_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] exp_b[4];
    int first;
    exp_b = '{8'hA1, 8'h0F, 8'h0F, 8'hA1};
    send(16'h0F0F, 4'h1);
    ncyc(PKT + 10);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dec_byte(40*i) !== exp_b[i]) begin errors++; $display("FAIL csum_byte%0d got %h exp %h", i, dec_byte(40*i), exp_b[i]); end
    end
    first = -1;
    foreach (done_log[k]) if (done_log[k] === 1'b1 && first < 0) first = k;
    checks++; if (first != 159) begin errors++; $display("FAIL csum_done_time got %0d exp 160", first + 1); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
`ifdef RESP_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
